// File: rtl/excl_hold_monitor_pkg.sv
// excl_mon_pkg: shared encodings and width helper for the exclusivity/hold monitor
package excl_mon_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EXCL = 2'b01,
        HOLD = 2'b10,
        BOTH = 2'b11
    } first_type_e;

    typedef enum logic {
        CLEAN   = 1'b0,
        FAULTED = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/excl_hold_monitor_if.sv
// excl_hold_monitor_if: monitored strobes, controls and debug outputs of the monitor
interface excl_hold_monitor_if #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 8
);
    localparam int IW = excl_mon_pkg::idx_w(N_CH);

    logic            en;
    logic [N_CH-1:0] sig;
    logic            clr;
    logic            err_excl;
    logic            err_hold;
    logic            err_pulse;
    logic [1:0]      first_type;
    logic [IW-1:0]   first_ch;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output en, sig, clr,
        input  err_excl, err_hold, err_pulse, first_type, first_ch, viol_cnt
    );

    modport slave (
        input  en, sig, clr,
        output err_excl, err_hold, err_pulse, first_type, first_ch, viol_cnt
    );

endinterface

// File: rtl/excl_hold_monitor_hold_timer.sv
// hold_timer: per-line saturating high-time counter, one hit per continuous assertion
module hold_timer #(
    parameter int MAX_HOLD = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic sig,
    output logic hit
);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [CW-1:0] cnt;
    logic          flagged;

    assign hit = (MAX_HOLD > 0) && en && sig && !flagged && (cnt == CW'(MAX_HOLD));

    // Count consecutive enabled high cycles; a low line or disabled check restarts it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            flagged <= 1'b0;
        end else if (!(en && sig)) begin
            cnt     <= '0;
            flagged <= 1'b0;
        end else begin
            cnt     <= (cnt == CW'(MAX_HOLD)) ? cnt : cnt + 1'b1;
            flagged <= flagged | hit;
        end
    end

endmodule

// File: rtl/excl_hold_monitor.sv
// excl_hold_monitor: sticky exclusivity / hold-timeout checker with first-fault capture
module excl_hold_monitor
    import excl_mon_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8,
    parameter int FATAL_EN = 1
) (
    input logic                clock,
    input logic                reset_n,
    excl_hold_monitor_if.slave bus
);
    localparam int IW = idx_w(N_CH);
    localparam int PW = $clog2(N_CH + 1);

    logic [N_CH-1:0]  hits;
    logic [PW-1:0]    pc;
    logic [IW-1:0]    sig_ch;
    logic [IW-1:0]    hold_ch;
    logic [IW-1:0]    ev_ch;
    logic             ev_excl;
    logic             ev_hold;
    logic             ev;
    first_type_e      ev_type;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_nx;

    state_e           state;
    logic             err_excl;
    logic             err_hold;
    logic             err_pulse;
    first_type_e      first_type;
    logic [IW-1:0]    first_ch;
    logic [CNT_W-1:0] viol_cnt;

    genvar i;
    for (i = 0; i < N_CH; i++) begin : g_ht
        hold_timer #(.MAX_HOLD(MAX_HOLD)) u_ht (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (bus.en),
            .sig     (bus.sig[i]),
            .hit     (hits[i])
        );
    end

    // Popcount plus lowest asserted line and lowest timed-out line
    always_comb begin
        pc      = '0;
        sig_ch  = '0;
        hold_ch = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            pc = pc + PW'(bus.sig[k]);
            if (bus.sig[k]) sig_ch = IW'(k);
            if (hits[k]) hold_ch = IW'(k);
        end
    end

    assign ev_excl = bus.en && ((pc > PW'(1)) || (MODE == 1 && pc == '0));
    assign ev_hold = |hits;
    assign ev      = ev_excl | ev_hold;
    assign ev_ch   = ev_excl ? sig_ch : hold_ch;
    assign ev_type = first_type_e'({ev_hold, ev_excl});
    assign sum     = {1'b0, bus.clr ? {CNT_W{1'b0}} : viol_cnt} + (CNT_W+1)'(ev_excl) + (CNT_W+1)'(ev_hold);
    assign cnt_nx  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    // Sticky flags, saturating count and first-fault capture; an event beats a same-cycle clr
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAN;
            err_excl   <= 1'b0;
            err_hold   <= 1'b0;
            err_pulse  <= 1'b0;
            first_type <= NONE;
            first_ch   <= '0;
            viol_cnt   <= '0;
        end else begin
            err_excl  <= ev_excl | (err_excl & ~bus.clr);
            err_hold  <= ev_hold | (err_hold & ~bus.clr);
            err_pulse <= ev;
            viol_cnt  <= cnt_nx;
            if (ev && (state == CLEAN || bus.clr)) begin
                state      <= FAULTED;
                first_type <= ev_type;
                first_ch   <= ev_ch;
            end else if (bus.clr) begin
                state      <= CLEAN;
                first_type <= NONE;
                first_ch   <= '0;
            end
        end
    end

    assign bus.err_excl   = err_excl;
    assign bus.err_hold   = err_hold;
    assign bus.err_pulse  = err_pulse;
    assign bus.first_type = first_type;
    assign bus.first_ch   = first_ch;
    assign bus.viol_cnt   = viol_cnt;

`ifndef SYNTHESIS
`ifndef PRINTF_COND
`define PRINTF_COND 1
`endif
`ifndef STOP_COND
`define STOP_COND 1
`endif
    if (FATAL_EN != 0) begin : g_fatal
        // Halt simulation on the transition into the faulted state
        always @(posedge clock) begin
            if (reset_n && state == CLEAN && ev) begin
                if (`PRINTF_COND) $display("excl_hold_monitor %m: first violation type %0d ch %0d", ev_type, ev_ch);
                if (`STOP_COND) $fatal(1, "excl_hold_monitor %m: violation");
            end
        end
    end
`endif

endmodule

// File: tb/tb_excl_hold_monitor.sv
// tb_excl_hold_monitor: directed vector table plus multi-cycle corner sequences
module tb_excl_hold_monitor;
    import excl_mon_pkg::*;

    typedef struct {
        logic       en;
        logic [2:0] sig;
        logic       clr;
        logic       ex;
        logic       ho;
        logic       pu;
        logic [1:0] ty;
        logic [1:0] ch;
        logic [1:0] cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    vec_t tv[17];

    always #5 clock = ~clock;

    excl_hold_monitor_if #(.N_CH(3), .CNT_W(2)) a_if ();
    excl_hold_monitor_if #(.N_CH(3), .CNT_W(8)) b_if ();

    excl_hold_monitor #(.N_CH(3), .MODE(0), .MAX_HOLD(4), .CNT_W(2), .FATAL_EN(0)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (a_if)
    );

    excl_hold_monitor #(.N_CH(3), .MODE(1), .MAX_HOLD(4), .CNT_W(8), .FATAL_EN(0)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b_if)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_a(input string t, input int ex, input int ho, input int pu, input int ty, input int ch, input int cnt);
        chk({t, ".err_excl"}, int'(a_if.err_excl), ex);
        chk({t, ".err_hold"}, int'(a_if.err_hold), ho);
        chk({t, ".err_pulse"}, int'(a_if.err_pulse), pu);
        chk({t, ".first_type"}, int'(a_if.first_type), ty);
        chk({t, ".first_ch"}, int'(a_if.first_ch), ch);
        chk({t, ".viol_cnt"}, int'(a_if.viol_cnt), cnt);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [2:0] sig, input logic clr);
        a_if.en  = en;
        a_if.sig = sig;
        a_if.clr = clr;
    endtask

    initial begin
        tv[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[1]  = '{1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 2'd1};
        tv[2]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'd0, 2'd1};
        tv[3]  = '{1'b1, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 2'd1};
        tv[4]  = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[5]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 2'd1};
        tv[6]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 2'd2};
        tv[7]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 2'd3};
        tv[8]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 2'd3};
        tv[9]  = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'd0, 2'd3};
        tv[10] = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'd0, 2'd3};
        tv[11] = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[12] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[13] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[14] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[15] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0};
        tv[16] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'd2, 2'd1};

        drive_a(1'b0, 3'b000, 1'b0);
        b_if.en  = 1'b0;
        b_if.sig = 3'b000;
        b_if.clr = 1'b0;
        #12;
        chk_a("reset_a", 0, 0, 0, 0, 0, 0);
        chk("reset_b.viol_cnt", int'(b_if.viol_cnt), 0);
        chk("reset_b.first_type", int'(b_if.first_type), 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 17; v++) begin
            drive_a(tv[v].en, tv[v].sig, tv[v].clr);
            tick();
            chk_a($sformatf("vec%0d", v), tv[v].ex, tv[v].ho, tv[v].pu, tv[v].ty, tv[v].ch, tv[v].cnt);
        end

        for (int c = 0; c < 15; c++) begin
            tick();
            chk($sformatf("long_hold%0d.err_pulse", c), int'(a_if.err_pulse), 0);
            chk($sformatf("long_hold%0d.viol_cnt", c), int'(a_if.viol_cnt), 1);
        end
        drive_a(1'b1, 3'b000, 1'b0);
        tick();
        chk_a("hold_fall", 0, 1, 0, 2, 2, 1);
        drive_a(1'b1, 3'b100, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rehold%0d.err_pulse", c), int'(a_if.err_pulse), 0);
        end
        tick();
        chk_a("rehold_event", 0, 1, 1, 2, 2, 2);

        drive_a(1'b1, 3'b000, 1'b1);
        tick();
        chk_a("clr_alone", 0, 0, 0, 0, 0, 0);
        drive_a(1'b1, 3'b100, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        chk_a("pre_both", 0, 0, 0, 0, 0, 0);
        drive_a(1'b1, 3'b110, 1'b0);
        tick();
        chk_a("both_same_cycle", 1, 1, 1, 3, 1, 2);

        drive_a(1'b0, 3'b101, 1'b1);
        tick();
        chk_a("en_low_clr", 0, 0, 0, 0, 0, 0);
        drive_a(1'b0, 3'b101, 1'b0);
        tick();
        chk_a("en_low", 0, 0, 0, 0, 0, 0);

        drive_a(1'b1, 3'b001, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        drive_a(1'b0, 3'b001, 1'b0);
        tick();
        drive_a(1'b1, 3'b001, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("en_restart%0d.err_pulse", c), int'(a_if.err_pulse), 0);
        end
        tick();
        chk_a("en_restart_event", 0, 1, 1, 2, 0, 1);

        drive_a(1'b1, 3'b000, 1'b1);
        tick();
        drive_a(1'b1, 3'b101, 1'b0);
        tick();
        chk_a("pre_reset_excl", 1, 0, 1, 1, 0, 1);
        drive_a(1'b1, 3'b001, 1'b0);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_reset%0d.err_pulse", c), int'(a_if.err_pulse), 0);
        end
        tick();
        chk_a("post_reset_event", 0, 1, 1, 2, 0, 1);

        b_if.en  = 1'b1;
        b_if.sig = 3'b000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("zero_hot%0d.viol_cnt", c), int'(b_if.viol_cnt), c);
            chk($sformatf("zero_hot%0d.err_pulse", c), int'(b_if.err_pulse), 1);
        end
        chk("zero_hot.err_excl", int'(b_if.err_excl), 1);
        chk("zero_hot.first_type", int'(b_if.first_type), 1);
        chk("zero_hot.first_ch", int'(b_if.first_ch), 0);
        b_if.sig = 3'b001;
        tick();
        chk("one_hot_ok.err_pulse", int'(b_if.err_pulse), 0);
        chk("one_hot_ok.viol_cnt", int'(b_if.viol_cnt), 3);
        b_if.en  = 1'b0;
        b_if.sig = 3'b000;
        b_if.clr = 1'b1;
        tick();
        b_if.clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("zero_hot_dis%0d.err_excl", c), int'(b_if.err_excl), 0);
            chk($sformatf("zero_hot_dis%0d.viol_cnt", c), int'(b_if.viol_cnt), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
